// File: rtl/uart_rx_oversampler.sv
// 16x-oversampling 8N1 UART receive deserializer with start/complete/framing-error pulses.
// Define RX_MAJORITY_EN to take each sample as the 3-tick majority of the synchronized line.
module uart_rx_oversampler #(
  parameter int unsigned CLK_DIV   = 26,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 rx_start,
  output logic                 rx_complete,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned DIV_W  = $clog2(CLK_DIV);
  localparam int unsigned BCNT_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t               state;
  state_t               state_next;
  logic                 rx_meta;
  logic                 rxs;
  logic [DIV_W-1:0]     div_cnt;
  logic                 tick;
  logic [3:0]           tcnt;
  logic [BCNT_W-1:0]    bcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 sample;
  logic                 start_c;
  logic                 complete_c;
  logic                 frame_err_c;

  assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

`ifdef RX_MAJORITY_EN
  // Line values from the two previous ticks; the current tick supplies the third vote.
  logic [1:0] hist;

  always_ff @(posedge clock) begin
    if (!reset) begin
      hist <= 2'b11;
    end else if (tick) begin
      hist <= {hist[0], rxs};
    end
  end

  assign sample = (hist[1] & hist[0]) | (hist[1] & rxs) | (hist[0] & rxs);
`else
  assign sample = rxs;
`endif

  // Two-flop synchronizer for the asynchronous line
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rxs     <= rx_meta;
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!rxs) state_next = START;
      end
      START: begin
        if (tick && (tcnt == 4'd7)) state_next = sample ? IDLE : DATA;
      end
      DATA: begin
        if (tick && (tcnt == 4'd15) && (bcnt == BCNT_W'(DATA_BITS - 1))) state_next = STOP;
      end
      STOP: begin
        if (tick && (tcnt == 4'd15)) state_next = sample ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (rxs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Pulse decode, registered below
  always_comb begin
    start_c     = 1'b0;
    complete_c  = 1'b0;
    frame_err_c = 1'b0;
    case (state)
      IDLE: start_c = !rxs;
      STOP: begin
        complete_c  = tick && (tcnt == 4'd15) && sample;
        frame_err_c = tick && (tcnt == 4'd15) && !sample;
      end
      default: ;
    endcase
  end

  // Tick divider, per-bit tick counter, bit counter and shift register
  always_ff @(posedge clock) begin
    if (!reset) begin
      div_cnt <= '0;
      tcnt    <= '0;
      bcnt    <= '0;
      shreg   <= '0;
    end else begin
      if (start_c || tick) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      case (state)
        IDLE: begin
          tcnt <= '0;
          bcnt <= '0;
        end
        START: begin
          if (tick) tcnt <= (tcnt == 4'd7) ? 4'd0 : tcnt + 4'd1;
        end
        DATA: begin
          if (tick) begin
            tcnt <= tcnt + 4'd1;
            if (tcnt == 4'd15) begin
              shreg <= {sample, shreg[DATA_BITS-1:1]};
              bcnt  <= bcnt + BCNT_W'(1);
            end
          end
        end
        STOP: begin
          if (tick) tcnt <= tcnt + 4'd1;
        end
        default: tcnt <= '0;
      endcase
    end
  end

  // Registered outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_byte     <= '0;
      rx_start    <= 1'b0;
      rx_complete <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rx_start    <= start_c;
      rx_complete <= complete_c;
      frame_err   <= frame_err_c;
      busy        <= (state_next != IDLE);
      if (complete_c) rx_byte <= shreg;
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Directed bench for uart_rx_oversampler at CLK_DIV=4, DATA_BITS=8 (64 clocks per bit).
module tb_uart_rx_oversampler;

  localparam int unsigned CLK_DIV  = 4;
  localparam int unsigned DB       = 8;
  localparam int          BIT_CLKS = 64;

  logic          clock;
  logic          reset;
  logic          rx_in;
  logic [DB-1:0] rx_byte;
  logic          rx_start;
  logic          rx_complete;
  logic          frame_err;
  logic          busy;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int n_start = 0;
  int n_complete = 0;
  int n_err = 0;
  int n_overlap = 0;
  int n_long = 0;
  int start_cyc = 0;
  int complete_cyc = 0;
  logic [7:0] got[$];
  logic p_start = 1'b0;
  logic p_comp = 1'b0;
  logic p_err = 1'b0;

  uart_rx_oversampler #(.CLK_DIV(CLK_DIV), .DATA_BITS(DB)) dut (
    .clock       (clock),
    .reset       (reset),
    .rx_in       (rx_in),
    .rx_byte     (rx_byte),
    .rx_start    (rx_start),
    .rx_complete (rx_complete),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pulse monitor, sampled just after each rising edge
  always @(posedge clock) begin
    #1;
    cyc++;
    if (rx_start) begin
      n_start++;
      start_cyc = cyc;
    end
    if (rx_complete) begin
      n_complete++;
      complete_cyc = cyc;
      got.push_back(rx_byte);
    end
    if (frame_err) n_err++;
    if ((32'(rx_start) + 32'(rx_complete) + 32'(frame_err)) > 1) n_overlap++;
    if ((rx_start && p_start) || (rx_complete && p_comp) || (frame_err && p_err)) n_long++;
    p_start = rx_start;
    p_comp  = rx_complete;
    p_err   = frame_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      rx_in = v;
    end
  endtask

  // gbit >= 0 inverts that data bit for 4 clocks around its centre sample
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int gbit);
    drive_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < DB; i++) begin
      if (i == gbit) begin
        drive_bit(b[i], 31);
        drive_bit(~b[i], 4);
        drive_bit(b[i], 29);
      end else begin
        drive_bit(b[i], BIT_CLKS);
      end
    end
    drive_bit(stop_v, BIT_CLKS);
  endtask

  int s0, c0, e0, qi;
  logic [7:0] glitch_exp;

  initial begin
    reset = 1'b0;
    rx_in = 1'b1;
    repeat (4) @(negedge clock);
    check("rst_byte", 32'(rx_byte), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_start", 32'(rx_start), 32'h0);
    check("rst_complete", 32'(rx_complete), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    reset = 1'b1;
    drive_bit(1'b1, 10);

    // single 0x55 frame
    s0 = n_start; c0 = n_complete; e0 = n_err;
    send_frame(8'h55, 1'b1, -1);
    drive_bit(1'b1, 5);
    check("t1_starts", 32'(n_start - s0), 32'd1);
    check("t1_completes", 32'(n_complete - c0), 32'd1);
    check("t1_byte", 32'(rx_byte), 32'h55);
    check("t1_latency", 32'(complete_cyc - start_cyc), 32'd608);
    check("t1_ferr", 32'(n_err - e0), 32'd0);
    check("t1_busy", 32'(busy), 32'h0);

    // back-to-back frames, no idle gap
    c0 = n_complete; qi = got.size();
    send_frame(8'hA3, 1'b1, -1);
    send_frame(8'h0F, 1'b1, -1);
    drive_bit(1'b1, 5);
    check("t2_completes", 32'(n_complete - c0), 32'd2);
    check("t2_byte0", (got.size() > qi) ? 32'(got[qi]) : 32'hFFFF_FFFF, 32'hA3);
    check("t2_byte1", (got.size() > qi + 1) ? 32'(got[qi+1]) : 32'hFFFF_FFFF, 32'h0F);
    check("t2_last", 32'(rx_byte), 32'h0F);

    // short low glitch while idle
    s0 = n_start; c0 = n_complete; e0 = n_err;
    drive_bit(1'b0, 20);
    drive_bit(1'b1, 100);
    check("t3_starts", 32'(n_start - s0), 32'd1);
    check("t3_completes", 32'(n_complete - c0), 32'd0);
    check("t3_ferr", 32'(n_err - e0), 32'd0);
    check("t3_busy", 32'(busy), 32'h0);

    // framing error followed by a held-low break
    c0 = n_complete; e0 = n_err;
    send_frame(8'h81, 1'b0, -1);
    drive_bit(1'b0, 2000);
    check("t4_ferr", 32'(n_err - e0), 32'd1);
    check("t4_busy_hold", 32'(busy), 32'h1);
    drive_bit(1'b1, 10);
    check("t4_busy_rel", 32'(busy), 32'h0);
    check("t4_byte_kept", 32'(rx_byte), 32'h0F);
    check("t4_completes", 32'(n_complete - c0), 32'd0);
    check("t4_ferr_once", 32'(n_err - e0), 32'd1);

    // reset in the middle of data bit 3 of a 0xFF frame
    c0 = n_complete; e0 = n_err;
    drive_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 3; i++) drive_bit(1'b1, BIT_CLKS);
    drive_bit(1'b1, 32);
    reset = 1'b0;
    drive_bit(1'b1, 3);
    check("t5_rst_byte", 32'(rx_byte), 32'h0);
    check("t5_rst_busy", 32'(busy), 32'h0);
    reset = 1'b1;
    drive_bit(1'b1, BIT_CLKS * 2);
    check("t5_no_complete", 32'(n_complete - c0), 32'd0);
    check("t5_no_ferr", 32'(n_err - e0), 32'd0);
    send_frame(8'h3C, 1'b1, -1);
    drive_bit(1'b1, 5);
    check("t5_byte", 32'(rx_byte), 32'h3C);
    check("t5_completes", 32'(n_complete - c0), 32'd1);

    // one-tick glitch at the centre of data bit 3
`ifdef RX_MAJORITY_EN
    glitch_exp = 8'h00;
`else
    glitch_exp = 8'h08;
`endif
    c0 = n_complete;
    send_frame(8'h00, 1'b1, 3);
    drive_bit(1'b1, 5);
    check("t6_completes", 32'(n_complete - c0), 32'd1);
    check("t6_byte", 32'(rx_byte), 32'(glitch_exp));

    check("pulse_overlap", 32'(n_overlap), 32'd0);
    check("pulse_width", 32'(n_long), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
